// File: rtl/lcd_hd44780_phy.sv
// Byte-level HD44780 write engine: power-on wait, RS/D setup, EN strobe, hold,
// then the controller execution wait before reporting completion.
module lcd_hd44780_phy #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 2,
    parameter int EXEC_CYC  = 1250,
    parameter int CLR_CYC   = 50000,
    parameter int PWRUP_CYC = 1250000,
    parameter int CNT_W     = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cd,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done_tick,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic [7:0] lcd_d
);

    typedef enum logic [2:0] {PWRUP, IDLE, SETUP, ENHI, HOLD, EXEC} state_t;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_clr;
    logic [CNT_W-1:0] exec_ld;

    assign lcd_rw  = 1'b0;
    assign exec_ld = is_clr ? CLR_LD : EXEC_LD;

    // Each timed state exits when the counter reaches zero and reloads it for the
    // next state; done_tick is set one edge early so it lands in the last EXEC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PWRUP;
            cnt       <= PWRUP_LD;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_d     <= 8'h00;
            done_tick <= 1'b0;
            busy      <= 1'b1;
            is_clr    <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                PWRUP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    lcd_en <= 1'b0;
                    if (start) begin
                        lcd_d  <= data;
                        lcd_rs <= cd;
                        is_clr <= !cd && (data == 8'h01 || data == 8'h02 || data == 8'h03);
                        state  <= SETUP;
                        cnt    <= SETUP_LD;
                        busy   <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= ENHI;
                        cnt    <= EN_LD;
                        lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ENHI: begin
                    if (cnt == '0) begin
                        state  <= HOLD;
                        cnt    <= HOLD_LD;
                        lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state     <= EXEC;
                        cnt       <= exec_ld;
                        done_tick <= (exec_ld == '0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt       <= cnt - 1'b1;
                        done_tick <= (cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state  <= PWRUP;
                    cnt    <= PWRUP_LD;
                    lcd_en <= 1'b0;
                    busy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_phy.sv
// Self-checking bench for lcd_hd44780_phy: a vector table plus hand-written
// sequences, with a scoreboard queue checked on every EN pulse and done_tick.
module tb_lcd_hd44780_phy;

    localparam int S = 2;
    localparam int E = 4;
    localparam int H = 2;
    localparam int X = 10;
    localparam int C = 40;
    localparam int P = 100;
    localparam int SHORT_LAT = S + E + H + X;
    localparam int CLR_LAT   = S + E + H + C;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cd = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy, done_tick, lcd_rs, lcd_en, lcd_rw;
    logic [7:0] lcd_d;

    lcd_hd44780_phy #(
        .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
        .EXEC_CYC(X), .CLR_CYC(C), .PWRUP_CYC(P), .CNT_W(21)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cd(cd), .data(data),
        .busy(busy), .done_tick(done_tick), .lcd_rs(lcd_rs),
        .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         t0;
        int         lat;
    } item_t;

    typedef struct {
        logic       cd;
        logic [7:0] d;
        int         lat;
    } vec_t;

    item_t exp_q[$];
    item_t pend_q[$];
    int    checks = 0;
    int    errors = 0;
    int    en_rises = 0;
    int    dones = 0;
    int    en_start = 0;
    logic  en_prev = 1'b0;
    logic  after_done = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic item_t mkItem(input logic [7:0] d, input logic rs, input int t0, input int lat);
        item_t it;
        it.d = d;
        it.rs = rs;
        it.t0 = t0;
        it.lat = lat;
        return it;
    endfunction

    // Scoreboard monitor: pops the expected transfer on each EN rise, checks the
    // strobe width on the fall and the completion latency on done_tick.
    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            en_prev = 1'b0;
            after_done = 1'b0;
        end else begin
            if (after_done) begin
                checkOutput("busy_after_done", busy, 0);
                after_done = 1'b0;
            end
            if (lcd_en && !en_prev) begin
                en_rises++;
                en_start = cyc;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_en", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    checkOutput("en_rise_d", lcd_d, it.d);
                    checkOutput("en_rise_rs", lcd_rs, it.rs);
                    checkOutput("en_rise_lat", cyc - it.t0, S + 1);
                    pend_q.push_back(it);
                end
            end
            if (!lcd_en && en_prev) begin
                checkOutput("en_width", cyc - en_start, E);
                if (pend_q.size() != 0) begin
                    checkOutput("en_fall_d", lcd_d, pend_q[pend_q.size()-1].d);
                    checkOutput("en_fall_rs", lcd_rs, pend_q[pend_q.size()-1].rs);
                end
            end
            if (done_tick) begin
                dones++;
                after_done = 1'b1;
                if (pend_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    it = pend_q.pop_front();
                    checkOutput("done_lat", cyc - it.t0, it.lat);
                end
            end
            en_prev = lcd_en;
        end
    end

    task automatic waitIdle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic waitDone();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_tick) return;
        end
        checkOutput("done_timeout", 1, 0);
    endtask

    task automatic waitEn();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (lcd_en) return;
        end
        checkOutput("en_timeout", 1, 0);
    endtask

    // One transfer: either a one-cycle start pulse or a sequencer-style start
    // held until done_tick.
    task automatic applyStimulus(input logic c, input logic [7:0] d, input int lat, input bit hold);
        waitIdle();
        cd = c;
        data = d;
        start = 1'b1;
        exp_q.push_back(mkItem(d, c, cyc, lat));
        if (hold) begin
            waitDone();
        end else begin
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Release reset with start held and check the power-on window stays quiet.
    task automatic releaseAndPowerUp(input logic c, input logic [7:0] d, input int lat);
        int bad;
        cd = c;
        data = d;
        start = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.push_back(mkItem(d, c, cyc + P, lat));
        bad = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (!busy || lcd_en) bad++;
        end
        checkOutput("pwrup_quiet", bad, 0);
        @(negedge clk);
        checkOutput("first_idle_busy", busy, 0);
        @(negedge clk);
        checkOutput("accept_busy", busy, 1);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   base;
        int   bad;
        int   d0;
        int   tdone;

        vecs[0] = '{1'b1, 8'h48, SHORT_LAT};
        vecs[1] = '{1'b0, 8'h01, CLR_LAT};
        vecs[2] = '{1'b1, 8'h01, SHORT_LAT};
        vecs[3] = '{1'b0, 8'h02, CLR_LAT};
        vecs[4] = '{1'b0, 8'h03, CLR_LAT};
        vecs[5] = '{1'b0, 8'h04, SHORT_LAT};
        vecs[6] = '{1'b1, 8'h02, SHORT_LAT};
        vecs[7] = '{1'b0, 8'h00, SHORT_LAT};

        data = 8'hA5;
        cd = 1'b1;
        #23;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_en", lcd_en, 0);
        checkOutput("rst_rs", lcd_rs, 0);
        checkOutput("rst_d", lcd_d, 8'h00);
        checkOutput("rst_done", done_tick, 0);
        checkOutput("rst_rw", lcd_rw, 0);

        releaseAndPowerUp(1'b0, 8'h38, SHORT_LAT);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].cd, vecs[i].d, vecs[i].lat, 1'b0);
        end

        // Back-to-back: start stays high through done_tick with new data.
        waitIdle();
        base = en_rises;
        cd = 1'b0;
        data = 8'h50;
        start = 1'b1;
        exp_q.push_back(mkItem(8'h50, 1'b0, cyc, SHORT_LAT));
        waitDone();
        tdone = cyc;
        data = 8'h51;
        exp_q.push_back(mkItem(8'h51, 1'b0, tdone + 1, SHORT_LAT));
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        checkOutput("b2b_pulses", en_rises - base, 2);

        // Sequencer-style run of 33 bytes.
        base = en_rises;
        for (int i = 0; i < 33; i++) begin
            applyStimulus(1'b1, 8'h20 + 8'(i), SHORT_LAT, 1'b1);
        end
        waitIdle();
        checkOutput("seq_pulses", en_rises - base, 33);
        checkOutput("seq_exp_empty", exp_q.size(), 0);
        checkOutput("seq_pend_empty", pend_q.size(), 0);

        // Data changes while busy must not reach the pins.
        waitIdle();
        cd = 1'b0;
        data = 8'h41;
        start = 1'b1;
        exp_q.push_back(mkItem(8'h41, 1'b0, cyc, SHORT_LAT));
        @(negedge clk);
        start = 1'b0;
        waitEn();
        data = 8'hFF;
        bad = 0;
        for (int n = 0; n < 200 && busy; n++) begin
            @(negedge clk);
            if (lcd_d !== 8'h41) bad++;
        end
        checkOutput("d_stable_busy", bad, 0);
        checkOutput("d_idle_hold", lcd_d, 8'h41);

        // Reset during ENHI aborts the transfer and restarts the power-on wait.
        waitIdle();
        cd = 1'b1;
        data = 8'h55;
        start = 1'b1;
        exp_q.push_back(mkItem(8'h55, 1'b1, cyc, SHORT_LAT));
        @(negedge clk);
        start = 1'b0;
        waitEn();
        @(posedge clk);
        #2;
        d0 = dones;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_en", lcd_en, 0);
        checkOutput("rst_async_busy", busy, 1);
        exp_q.delete();
        pend_q.delete();
        repeat (3) @(negedge clk);
        releaseAndPowerUp(1'b0, 8'h39, SHORT_LAT);
        checkOutput("no_done_after_abort", dones - d0, 0);
        waitIdle();
        repeat (2) @(negedge clk);
        checkOutput("final_exp_empty", exp_q.size(), 0);
        checkOutput("final_pend_empty", pend_q.size(), 0);
        checkOutput("final_rw", lcd_rw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_phy.md
Name: lcd_hd44780_phy

Overview:
- Byte-level HD44780 write engine. It sits directly downstream of the LCD sequencer FSM and drives the pmod-charlcd pins.
- Accepts one byte plus a command/data flag per transfer. Generates RS/EN/D timing, then waits out the controller execution time before signalling completion.
- Enforces the power-on delay after reset, so upstream FSMs need no timing knowledge.

Parameters:
- SETUP_CYC, 2: cycles RS/D are stable before EN rises (80 ns at 25 MHz).
- EN_CYC, 12: cycles EN is held high (480 ns).
- HOLD_CYC, 2: cycles RS/D are held after EN falls.
- EXEC_CYC, 1250: execution wait for normal commands and data (50 us).
- CLR_CYC, 50000: execution wait for clear/home commands (2 ms).
- PWRUP_CYC, 1250000: power-on wait after reset release (50 ms).
- CNT_W, 21: delay counter width. Every *_CYC value is in the range 1..2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  level request. Sampled only in IDLE.
- cd  in  1  0 = command (RS low), 1 = data (RS high). Sampled with start.
- data  in  8  byte to write. Sampled with start.
- busy  out  1  high whenever the state is not IDLE.
- done_tick  out  1  one-cycle pulse in the last EXEC cycle.
- lcd_rs  out  1  register select to the LCD.
- lcd_en  out  1  enable strobe to the LCD.
- lcd_rw  out  1  constant 0 (write only).
- lcd_d  out  8  LCD data bus.

Behaviour:
- Reset values (rst=0, asynchronous): state=PWRUP, counter=PWRUP_CYC-1, lcd_en=0, lcd_rs=0, lcd_d=8'h00, lcd_rw=0, done_tick=0, busy=1.
- Asserting rst mid-transfer drops EN immediately, discards the transfer without a done_tick, and restarts the full power-on wait.
- All outputs are registered. One down-counter of CNT_W bits is reloaded on every state entry.
- State PWRUP: count down PWRUP_CYC cycles, then go to IDLE. start is ignored, not queued. A start still held high is accepted on the first IDLE cycle.
- State IDLE: busy=0.
  - If start=1, latch data and cd.
  - Next cycle: lcd_d=data, lcd_rs=cd, state=SETUP.
  - If start=0, stay in IDLE. lcd_d and lcd_rs keep their last values; lcd_en=0.
- State SETUP: SETUP_CYC cycles with EN low, then ENHI.
- State ENHI: lcd_en=1 for exactly EN_CYC cycles, then HOLD.
- State HOLD: EN low for HOLD_CYC cycles. RS and D are unchanged.
- State EXEC: wait N cycles, then go to IDLE.
  - N=CLR_CYC if the latched cd=0 and the latched data is 8'h01, 8'h02 or 8'h03.
  - Otherwise N=EXEC_CYC. This includes cd=1 with data 8'h01.
  - done_tick=1 in the last EXEC cycle only. The state is IDLE on the following cycle.
- Latency, with the IDLE cycle sampling start=1 as t0:
  - RS/D valid at t0+1.
  - EN rises at t0+1+SETUP_CYC.
  - EN falls at t0+1+SETUP_CYC+EN_CYC.
  - done_tick at t0+SETUP_CYC+EN_CYC+HOLD_CYC+N.
  - Total busy cycles per transfer = SETUP_CYC+EN_CYC+HOLD_CYC+N. Defaults give 1266 (short) and 50016 (clear/home).
- Handshake:
  - start is level-sensitive. Every IDLE cycle with start=1 launches a transfer.
  - The sequencer drops start in response to done_tick (start registered low the cycle after done_tick). No extra transfer then occurs.
  - If start stays high through done_tick, a new transfer starts on the first IDLE cycle using the data/cd present then. This is intended back-to-back operation.
- data and cd changes while busy=1 have no effect on the pins.
- The counter never wraps: each state exits on count==0 and reloads the next value.

Test Plan:
- Bench parameter overrides: SETUP=2, EN=4, HOLD=2, EXEC=10, CLR=40, PWRUP=100.
- Reset then release, start held high with cd=0, data=8'h38 -> busy=1 and no EN for 100 cycles. First IDLE cycle accepts the transfer. lcd_d=8'h38, lcd_rs=0. EN high exactly 4 cycles.
- In IDLE, one-shot start with cd=1, data=8'h48 ('H') -> RS=1 for the whole transfer. EN rises 3 cycles after sampling. done_tick single pulse 18 cycles after sampling. busy low the next cycle.
- cd=0, data=8'h01 -> exec wait 40 cycles, done_tick 48 cycles after sampling. Repeat with cd=1, data=8'h01 -> 18 cycles.
- Sequencer-style run: 33 bytes, start dropped the cycle after each done_tick -> exactly 33 EN pulses, bytes in order, no duplicates.
- Change data to 8'hFF mid-ENHI -> lcd_d stays at the original byte until the next transfer.
- Assert rst during ENHI -> lcd_en=0 asynchronously, no done_tick, a full 100-cycle PWRUP before the next EN.
